// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state encodings and next-PC select codes for the PC unit
package pc_pkg;

   localparam logic [1:0] STATE_BOOT = 2'd0;
   localparam logic [1:0] STATE_RUN  = 2'd1;
   localparam logic [1:0] STATE_HALT = 2'd2;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JUMP,
      SEL_RET,
      SEL_TRAP
   } pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);
   import pc_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_inc;
   logic [PW-1:0]    ptr_dec;
   logic [CW-1:0]    count;
   logic             pop_ok;

   assign ptr_inc = ptr + 1'b1;
   assign ptr_dec = ptr - 1'b1;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign top     = mem[ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr   <= '0;
         count <= '0;
      end else if (push && pop_ok) begin
         // pop-then-push: top slot is rewritten in place, depth unchanged
         ptr   <= ptr;
         count <= count;
      end else if (push) begin
         ptr <= ptr_inc;
         if (!full)
            count <= count + 1'b1;
      end else if (pop_ok) begin
         ptr   <= ptr_dec;
         count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         if (pop_ok)
            mem[ptr] <= data;
         else
            mem[ptr_inc] <= data;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with BOOT/RUN/HALT control and call/return stack
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter int unsigned      STEP         = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h80,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             trap_req,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             link,
   input  logic             ret,
   input  logic [WIDTH-1:0] ret_fallback,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic             fetch_valid,
   output logic             halted,
   output logic             ras_empty,
   output logic             ras_full
);
   import pc_pkg::*;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   pc_sel_t          sel;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] ras_top;
   logic             ras_push;
   logic             ras_pop;
   logic             advance;

   assign pc_seq      = pc + WIDTH'(STEP);
   assign fetch_valid = (state == STATE_RUN);
   assign halted      = (state == STATE_HALT);

   always_comb begin
      state_nxt = state;
      sel       = SEL_HOLD;
      advance   = 1'b0;
      case (state)
         STATE_BOOT: state_nxt = STATE_RUN;
         STATE_RUN: begin
            if (trap_req)
               sel = SEL_TRAP;
            else if (stall)
               sel = SEL_HOLD;
            else if (halt_req)
               state_nxt = STATE_HALT;
            else begin
               advance = 1'b1;
               if (ret)
                  sel = SEL_RET;
               else if (jump)
                  sel = SEL_JUMP;
               else if (branch_taken)
                  sel = SEL_BRANCH;
               else
                  sel = SEL_SEQ;
            end
         end
         STATE_HALT: begin
            if (trap_req) begin
               sel       = SEL_TRAP;
               state_nxt = STATE_RUN;
            end
         end
         default: state_nxt = STATE_BOOT;
      endcase
   end

   // a call pushes even when a simultaneous return takes the pc
   assign ras_push = advance && jump && link;
   assign ras_pop  = advance && ret && !ras_empty;

   always_comb begin
      pc_nxt = pc;
      case (sel)
         SEL_SEQ:    pc_nxt = pc_seq;
         SEL_BRANCH: pc_nxt = branch_target;
         SEL_JUMP:   pc_nxt = jump_target;
         SEL_RET:    pc_nxt = ras_empty ? ret_fallback : ras_top;
         SEL_TRAP:   pc_nxt = TRAP_VECTOR;
         default:    pc_nxt = pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= STATE_BOOT;
         pc    <= RESET_VECTOR;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (ras_push),
      .pop   (ras_pop),
      .data  (pc_seq),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

endmodule
